rf_wb_arbiter: RTL and testbench

Write-side companion of the register file: owns the single RF write port and merges two result sources, the in-order pipeline writeback and the long-latency multiply/divide unit (MDU). MDU results are buffered in a small FIFO and written only in cycles the pipeline leaves the port free. A destination scoreboard tells decode which registers still await an MDU result. Sits between the WB stage / MDU and the RF write port (`we`/`wR`/`wD`).

---
 rtl/rf_wb_pkg.sv | 14 +
 rtl/rf_wb_arbiter_fifo.sv | 60 ++++++
 rtl/rf_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared widths and the writeback request type for the RF write-side logic.
package rf_wb_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  // One pending register-file write: destination and data.
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// wb_fifo: small synchronous FIFO of wb_req_t with a combinational head.
// The head is read combinationally because the RF write port is driven
// straight from it in the popping cycle; DEPTH is tiny, so this is a register
// array rather than a block RAM.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wb_req_t                  push_req,
  input  logic                     pop,
  output wb_req_t                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t         mem_reg [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_req;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: owns the RF write port. The pipeline writeback always wins;
// buffered MDU results drain into cycles the pipeline leaves free. A busy
// scoreboard tells decode which registers still await an MDU result.
// Optional same-cycle forwarding is enabled with `define RF_WB_FWD_EN.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = rf_wb_pkg::AW,
  parameter int DW    = rf_wb_pkg::DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_we,
  input  logic [AW-1:0]            pipe_wr,
  input  logic [DW-1:0]            pipe_wd,
  input  logic                     mdu_issue,
  input  logic [AW-1:0]            mdu_issue_rd,
  input  logic                     mdu_valid,
  input  logic [AW-1:0]            mdu_rd,
  input  logic [DW-1:0]            mdu_wd,
  output logic                     mdu_ready,
  input  logic [AW-1:0]            rR1,
  input  logic [AW-1:0]            rR2,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [DW-1:0]            fwd_wd,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_wr,
  output logic [DW-1:0]            rf_wd,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  wb_req_t          push_req;
  wb_req_t          head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             slot_used;
  logic             pop;
  logic             push;
  logic [NREG-1:0]  busy_reg;
  logic [NREG-1:0]  busy_next;

  // Writes to x0 are meaningless, so they leave the port free for the FIFO.
  assign slot_used = pipe_we & (pipe_wr != '0);
  assign pop       = ~slot_used & ~fifo_empty;

  // Readiness depends only on registered occupancy: a full FIFO refuses
  // even while popping, which keeps mdu_ready free of input paths.
  assign mdu_ready = ~fifo_full;
  assign push      = mdu_valid & mdu_ready & (mdu_rd != '0);
  assign push_req  = '{rd: mdu_rd, wd: mdu_wd};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // RF write port mux: pipeline first, then FIFO head, otherwise idle zeros.
  always_comb begin
    rf_we = 1'b0;
    rf_wr = '0;
    rf_wd = '0;
    if (slot_used) begin
      rf_we = 1'b1;
      rf_wr = pipe_wr;
      rf_wd = pipe_wd;
    end else if (pop) begin
      rf_we = 1'b1;
      rf_wr = head.rd;
      rf_wd = head.wd;
    end
  end

  // Per-register next busy state; a same-cycle set beats the clear.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign busy_next[gi] = 1'b0;
      end else begin : g_rn
        logic set_bit;
        logic clr_bit;
        assign set_bit = mdu_issue & (mdu_issue_rd == AW'(gi));
        assign clr_bit = pop & (head.rd == AW'(gi));
        assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
      end
    end
  endgenerate

  // Scoreboard register; reset drops every outstanding MDU result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  assign busy1 = (rR1 != '0) & busy_reg[rR1];
  assign busy2 = (rR2 != '0) & busy_reg[rR2];

`ifdef RF_WB_FWD_EN
  assign fwd1_hit = rf_we & (rf_wr == rR1) & (rR1 != '0);
  assign fwd2_hit = rf_we & (rf_wr == rR2) & (rR2 != '0);
  assign fwd_wd   = rf_wd;
`else
  assign fwd1_hit = 1'b0;
  assign fwd2_hit = 1'b0;
  assign fwd_wd   = '0;
`endif

  // Decode stalls on busy, so a second issue to a pending rd is a bug upstream.
  a_no_double_issue : assert property (@(posedge clk) disable iff (!rst_n)
    !(mdu_issue && (mdu_issue_rd != '0) && busy_reg[mdu_issue_rd]));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, scoreboard, pipeline priority,
// FIFO full/drain, x0 handling, mid-flight reset and forwarding.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_wr = '0;
  logic [31:0] pipe_wd = '0;
  logic        mdu_issue = 1'b0;
  logic [4:0]  mdu_issue_rd = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_rd = '0;
  logic [31:0] mdu_wd = '0;
  logic        mdu_ready;
  logic [4:0]  rR1 = '0;
  logic [4:0]  rR2 = '0;
  logic        busy1, busy2, fwd1_hit, fwd2_hit;
  logic [31:0] fwd_wd;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic [1:0]  fifo_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_wr(pipe_wr), .pipe_wd(pipe_wd),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd),
    .mdu_ready(mdu_ready), .rR1(rR1), .rR2(rR2),
    .busy1(busy1), .busy2(busy2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd_wd(fwd_wd), .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd),
    .fifo_count(fifo_count)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_wr = 0; pipe_wd = 0;
    mdu_issue = 0; mdu_issue_rd = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_wd = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rR1 = 5'd1; rR2 = 5'd2;
    #2;
    total++; if (fifo_count !== 2'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", mdu_ready); end
    total++; if ({busy1, busy2} !== 2'b00) begin bad++; $display("FAIL reset_busy: got %b want 00", {busy1, busy2}); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    step();
    rst_n = 1'b1;
    step();
    total++; if ({rf_we, mdu_ready, fifo_count} !== 4'b0100) begin bad++; $display("FAIL idle_after_reset: got we/ready/count=%b want 0100", {rf_we, mdu_ready, fifo_count}); end
    $display("test_reset done");
  endtask

  task automatic test_issue_busy();
    rR1 = 5'd5;
    mdu_issue = 1; mdu_issue_rd = 5'd5;
    #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL busy_same_cycle: got %b want 0", busy1); end
    step();
    mdu_issue = 0;
    #1;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL busy_set: got %b want 1", busy1); end
    step();
    mdu_valid = 1; mdu_rd = 5'd5; mdu_wd = 32'hDEADBEEF;
    #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL mdu_not_direct: got rf_we=%b want 0", rf_we); end
    step();
    mdu_valid = 0;
    #1;
    total++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin bad++; $display("FAIL mdu_write: got we=%b wr=%0d wd=%h want 1/5/deadbeef", rf_we, rf_wr, rf_wd); end
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL busy_during_write: got %b want 1", busy1); end
    step();
    total++; if ({rf_we, busy1, fifo_count} !== 4'b0000) begin bad++; $display("FAIL busy_cleared: got we/busy/count=%b want 0000", {rf_we, busy1, fifo_count}); end
    $display("test_issue_busy done");
  endtask

  task automatic test_pipe_priority();
    pipe_we = 1; pipe_wr = 5'd3; pipe_wd = 32'h33;
    mdu_valid = 1; mdu_rd = 5'd7; mdu_wd = 32'h77;
    #1;
    total++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd3, 32'h33}) begin bad++; $display("FAIL pipe_write: got we=%b wr=%0d wd=%h want 1/3/33", rf_we, rf_wr, rf_wd); end
    step();
    mdu_rd = 5'd8; mdu_wd = 32'h88;
    #1;
    total++; if ({mdu_ready, fifo_count} !== 3'b101) begin bad++; $display("FAIL count_one: got ready/count=%b want 101", {mdu_ready, fifo_count}); end
    step();
    mdu_valid = 0;
    #1;
    total++; if ({mdu_ready, fifo_count} !== 3'b010) begin bad++; $display("FAIL full: got ready/count=%b want 010", {mdu_ready, fifo_count}); end
    step();
    #1;
    total++; if ({rf_wr, fifo_count} !== {5'd3, 2'd2}) begin bad++; $display("FAIL held_full: got wr=%0d count=%0d want 3/2", rf_wr, fifo_count); end
    step();
    // Pipeline idle: drain head 7; offer rd=10 while full (must be refused).
    pipe_we = 0;
    mdu_valid = 1; mdu_rd = 5'd10; mdu_wd = 32'hAA;
    #1;
    total++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd7, 32'h77}) begin bad++; $display("FAIL drain_first: got we=%b wr=%0d wd=%h want 1/7/77", rf_we, rf_wr, rf_wd); end
    total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready: got %b want 0", mdu_ready); end
    step();
    // Push rd=11 while popping rd=8: count stays at 1.
    mdu_rd = 5'd11; mdu_wd = 32'hBB;
    #1;
    total++; if ({rf_wr, rf_wd, fifo_count} !== {5'd8, 32'h88, 2'd1}) begin bad++; $display("FAIL drain_second: got wr=%0d wd=%h count=%0d want 8/88/1", rf_wr, rf_wd, fifo_count); end
    step();
    mdu_valid = 0;
    #1;
    total++; if ({rf_wr, rf_wd, fifo_count} !== {5'd11, 32'hBB, 2'd1}) begin bad++; $display("FAIL push_pop_same: got wr=%0d wd=%h count=%0d want 11/bb/1", rf_wr, rf_wd, fifo_count); end
    step();
    total++; if ({rf_we, fifo_count} !== 3'b000) begin bad++; $display("FAIL drained: got we/count=%b want 000", {rf_we, fifo_count}); end
    $display("test_pipe_priority done");
  endtask

  task automatic test_x0();
    mdu_valid = 1; mdu_rd = 5'd0; mdu_wd = 32'hFF;
    step();
    mdu_valid = 0;
    #1;
    total++; if ({rf_we, fifo_count} !== 3'b000) begin bad++; $display("FAIL mdu_x0_dropped: got we/count=%b want 000", {rf_we, fifo_count}); end
    pipe_we = 1; pipe_wr = 5'd3; pipe_wd = 32'h33;
    mdu_valid = 1; mdu_rd = 5'd9; mdu_wd = 32'h99;
    step();
    mdu_valid = 0;
    pipe_wr = 5'd0; pipe_wd = 32'h55;
    #1;
    total++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd9, 32'h99}) begin bad++; $display("FAIL pipe_x0_frees_slot: got we=%b wr=%0d wd=%h want 1/9/99", rf_we, rf_wr, rf_wd); end
    step();
    pipe_we = 0;
    #1;
    total++; if ({rf_we, fifo_count} !== 3'b000) begin bad++; $display("FAIL x0_drained: got we/count=%b want 000", {rf_we, fifo_count}); end
    $display("test_x0 done");
  endtask

  task automatic test_reset_midflight();
    rR1 = 5'd4;
    mdu_issue = 1; mdu_issue_rd = 5'd4;
    step();
    mdu_issue = 0;
    pipe_we = 1; pipe_wr = 5'd3; pipe_wd = 32'h33;
    mdu_valid = 1; mdu_rd = 5'd4; mdu_wd = 32'h44;
    step();
    mdu_valid = 0;
    #1;
    total++; if ({busy1, fifo_count} !== 3'b101) begin bad++; $display("FAIL queued_before_reset: got busy/count=%b want 101", {busy1, fifo_count}); end
    rst_n = 0;
    #1;
    total++; if ({busy1, mdu_ready, fifo_count} !== 4'b0100) begin bad++; $display("FAIL async_reset: got busy/ready/count=%b want 0100", {busy1, mdu_ready, fifo_count}); end
    pipe_we = 0;
    #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_no_write: got %b want 0", rf_we); end
    step();
    rst_n = 1;
    step();
    total++; if ({rf_we, busy1, fifo_count} !== 4'b0000) begin bad++; $display("FAIL after_reset_idle: got we/busy/count=%b want 0000", {rf_we, busy1, fifo_count}); end
    $display("test_reset_midflight done");
  endtask

  task automatic test_forward();
    pipe_we = 1; pipe_wr = 5'd6; pipe_wd = 32'h1234;
    rR2 = 5'd6;
    #1;
`ifdef RF_WB_FWD_EN
    total++; if ({fwd2_hit, fwd_wd} !== {1'b1, 32'h1234}) begin bad++; $display("FAIL fwd_hit: got hit=%b wd=%h want 1/1234", fwd2_hit, fwd_wd); end
`else
    total++; if ({fwd2_hit, fwd_wd} !== {1'b0, 32'h0}) begin bad++; $display("FAIL fwd_disabled: got hit=%b wd=%h want 0/0", fwd2_hit, fwd_wd); end
`endif
    rR2 = 5'd0;
    #1;
    total++; if (fwd2_hit !== 1'b0) begin bad++; $display("FAIL fwd_x0: got %b want 0", fwd2_hit); end
    step();
    idle_inputs();
    $display("test_forward done");
  endtask

  initial begin
    test_reset();
    test_issue_busy();
    test_pipe_priority();
    test_x0();
    test_reset_midflight();
    test_forward();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
